// File: rtl/traffic_pkg.sv
// Shared phase/state encodings and default cycle boundaries for the crossroad sequencer and decoder.
// Pure definitions: no latency, no flow control.
package traffic_pkg;

  localparam logic [1:0] PH_AGRN = 2'd0;
  localparam logic [1:0] PH_AYEL = 2'd1;
  localparam logic [1:0] PH_BGRN = 2'd2;
  localparam logic [1:0] PH_BYEL = 2'd3;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_NIGHT = 1'b1
  } state_t;

  localparam int A_GRN_LAST_DEF = 19;
  localparam int A_YEL_LAST_DEF = 23;
  localparam int B_GRN_LAST_DEF = 43;
  localparam int B_YEL_LAST_DEF = 47;
  localparam int MIN_REMAIN_DEF = 5;
  localparam int NIGHT_CODE_DEF = 63;

  function automatic logic [1:0] phase_of(input logic [5:0] q,
                                          input logic [5:0] a_grn_last,
                                          input logic [5:0] a_yel_last,
                                          input logic [5:0] b_grn_last);
    if (q <= a_grn_last)      return PH_AGRN;
    else if (q <= a_yel_last) return PH_AYEL;
    else if (q <= b_grn_last) return PH_BGRN;
    else                      return PH_BYEL;
  endfunction

endpackage

// File: rtl/traffic_seq_ctrl.sv
// Crossroad phase sequencer: steps Q once per qualified 1 Hz tick, with HOLD, demand shortening and night flash.
// All outputs registered, one cycle from TICK; HOLD freezes the sequence, there is no other backpressure.
module traffic_seq_ctrl
  import traffic_pkg::*;
#(
  parameter int A_GRN_LAST = A_GRN_LAST_DEF,
  parameter int A_YEL_LAST = A_YEL_LAST_DEF,
  parameter int B_GRN_LAST = B_GRN_LAST_DEF,
  parameter int B_YEL_LAST = B_YEL_LAST_DEF,
  parameter int MIN_REMAIN = MIN_REMAIN_DEF,
  parameter int NIGHT_CODE = NIGHT_CODE_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       HOLD,
  input  logic       NIGHT,
  input  logic       REQ_A,
  input  logic       REQ_B,
  output logic [5:0] Q,
  output logic [1:0] PHASE,
  output logic       NIGHT_ACT,
  output logic       FLASH
);

  localparam logic [5:0] AG     = 6'(A_GRN_LAST);
  localparam logic [5:0] AY     = 6'(A_YEL_LAST);
  localparam logic [5:0] BG     = 6'(B_GRN_LAST);
  localparam logic [5:0] BY     = 6'(B_YEL_LAST);
  localparam logic [5:0] NC     = 6'(NIGHT_CODE);
  localparam logic [5:0] B_LIM  = 6'(A_GRN_LAST - MIN_REMAIN);
  localparam logic [5:0] A_LIM  = 6'(B_GRN_LAST - MIN_REMAIN);
  localparam logic [5:0] A_JUMP = 6'(A_GRN_LAST + 1 - MIN_REMAIN);
  localparam logic [5:0] B_JUMP = 6'(B_GRN_LAST + 1 - MIN_REMAIN);

  state_t     state;
  logic       pend_a;
  logic       pend_b;
  logic       qt;
  logic [5:0] q_nxt;
  logic       to_night;
  logic       pend_a_set;
  logic       pend_b_set;

  // Demand windows: the part of each green that is still longer than MIN_REMAIN.
  function automatic logic in_win_b(input logic [5:0] q);
    return q <= B_LIM;
  endfunction

  function automatic logic in_win_a(input logic [5:0] q);
    return (q > AY) && (q <= A_LIM);
  endfunction

  assign qt         = TICK & ~HOLD;
  assign pend_a_set = pend_a | (REQ_A & in_win_a(Q));
  assign pend_b_set = pend_b | (REQ_B & in_win_b(Q));

  always_comb begin
    q_nxt    = Q + 6'd1;
    to_night = 1'b0;
    if (((Q == AY) || (Q == BY)) && NIGHT) begin
      to_night = 1'b1;
      q_nxt    = NC;
    end else if (Q == BY) begin
      q_nxt = 6'd0;
    end else if (pend_b && in_win_b(Q)) begin
      q_nxt = A_JUMP;
    end else if (pend_a && in_win_a(Q)) begin
      q_nxt = B_JUMP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RUN;
      Q         <= 6'd0;
      PHASE     <= PH_AGRN;
      NIGHT_ACT <= 1'b0;
      FLASH     <= 1'b0;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          pend_a <= pend_a_set;
          pend_b <= pend_b_set;
          if (qt) begin
            Q <= q_nxt;
            // Latches survive a step only while Q stays inside their window.
            pend_a <= pend_a_set & in_win_a(q_nxt);
            pend_b <= pend_b_set & in_win_b(q_nxt);
            if (to_night) begin
              state     <= ST_NIGHT;
              PHASE     <= PH_AGRN;
              NIGHT_ACT <= 1'b1;
              FLASH     <= 1'b1;
            end else begin
              PHASE <= phase_of(q_nxt, AG, AY, BG);
            end
          end
        end
        ST_NIGHT: begin
          if (qt) begin
            if (NIGHT) begin
              FLASH <= ~FLASH;
            end else begin
              state     <= ST_RUN;
              Q         <= 6'd0;
              PHASE     <= PH_AGRN;
              NIGHT_ACT <= 1'b0;
              FLASH     <= 1'b0;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
